// File: rtl/pipeline_skid.sv
// rtl/pipeline_skid.sv - two-entry registered skid buffer, fully registered in both directions
// Optional stall counter on stall_count_o when PIPELINE_SKID_STATS_EN is defined.
module pipeline_skid #(
  parameter int Width      = 32,
  parameter int CountWidth = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_valid_i,
  input  logic [Width-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_ready_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [1:0]       occ_o
`ifdef PIPELINE_SKID_STATS_EN
  ,
  output logic [CountWidth-1:0] stall_count_o
`endif
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             vld_q, rdy_q;
  logic [Width-1:0] main_q, skid_q;
  logic             wr_fire, rd_fire;
  logic             load_main, load_skid, main_from_skid;

  assign wr_fire = wr_valid_i && rdy_q;
  assign rd_fire = vld_q && rd_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (wr_fire) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          if (wr_fire && rd_fire) begin
            load_main = 1'b1;
          end else if (wr_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (rd_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (rd_fire) begin
            state_d        = BUSY;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // rdy_q stays low through reset and comes up on the first edge after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_d != EMPTY);
      rdy_q   <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_main) begin
      main_q <= main_from_skid ? skid_q : wr_data_i;
    end
    if (load_skid) begin
      skid_q <= wr_data_i;
    end
  end

  assign wr_ready_o = rdy_q;
  assign rd_valid_o = vld_q;
  assign rd_data_o  = main_q;
  assign occ_o      = state_q;

`ifdef PIPELINE_SKID_STATS_EN
  logic [CountWidth-1:0] stall_q;

  // Saturating count of cycles the downstream held off valid data; flush does not clear it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (vld_q && !rd_ready_i && (stall_q != {CountWidth{1'b1}})) begin
      stall_q <= stall_q + CountWidth'(1);
    end
  end

  assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_skid.sv
// tb/tb_pipeline_skid.sv - randomized scoreboard bench for pipeline_skid
// Exercises the stall counter too when PIPELINE_SKID_STATS_EN is defined.
module tb_pipeline_skid;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready;
  logic          rd_ready = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [1:0]    occ;
`ifdef PIPELINE_SKID_STATS_EN
  logic [CW-1:0] stall_count;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cycle = 0;
  int since_rst = 0;
  logic [W-1:0] model_q[$];
  int rd_cycles[$];
  int m_stall = 0;

  pipeline_skid #(.Width(W), .CountWidth(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .wr_valid_i   (wr_valid),
    .wr_data_i    (wr_data),
    .wr_ready_o   (wr_ready),
    .rd_ready_i   (rd_ready),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .occ_o        (occ)
`ifdef PIPELINE_SKID_STATS_EN
    ,
    .stall_count_o(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cycle++;
    if (!rst) since_rst++;
  end

  // Monitor: the model is an ordered queue of accepted words, at most two deep.
  always @(negedge clk) begin
    logic exp_ready, exp_valid;
    if (rst) begin
      model_q.delete();
      since_rst = 0;
      m_stall = 0;
    end else begin
      exp_ready = (since_rst > 0) && (model_q.size() < 2);
      exp_valid = (model_q.size() > 0);
      check("occ", 32'(occ), 32'(model_q.size()));
      check("wr_ready", 32'(wr_ready), 32'(exp_ready));
      check("rd_valid", 32'(rd_valid), 32'(exp_valid));
`ifdef PIPELINE_SKID_STATS_EN
      check("stall_count", 32'(stall_count), 32'(m_stall));
`endif
      if (exp_valid && !rd_ready && m_stall < (1 << CW) - 1) m_stall++;
      if (flush) begin
        model_q.delete();
      end else begin
        if (exp_valid) begin
          if (rd_ready) begin
            check("rd_pop", 32'(rd_data), 32'(model_q.pop_front()));
            rd_cycles.push_back(cycle);
          end else begin
            check("rd_hold", 32'(rd_data), 32'(model_q[0]));
          end
        end
        if (wr_valid && exp_ready) model_q.push_back(wr_data);
      end
    end
  end

  task automatic push(input logic [W-1:0] d);
    int t;
    logic acc;
    wr_valid = 1'b1;
    wr_data  = d;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = wr_ready;
      t++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: got no wr_ready, required accept of %0h", d);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    rd_ready = 1'b1;
    t = 0;
    while (occ != 2'd0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (occ != 2'd0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: occ %0d required 0", occ);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_occ", 32'(occ), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_ready", 32'(wr_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_valid = 1'b1;
    wr_data = 16'h00EE;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("ready_after_rst", 32'(wr_ready), 1);
    check("early_write_ignored", 32'(rd_valid), 0);

    rd_ready = 1'b1;
    push(16'h00A5);
    check("a5_data", 32'(rd_data), 32'h00A5);
    check("a5_valid", 32'(rd_valid), 1);
    @(posedge clk);
    #1;
    check("a5_gone", 32'(rd_valid), 0);

    rd_ready = 1'b0;
    fork
      begin
        push(16'h1);
        push(16'h2);
        push(16'h3);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("full_occ", 32'(occ), 2);
        check("full_ready", 32'(wr_ready), 0);
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
      end
    join
    drain();

    rd_cycles.delete();
    for (int i = 0; i < 100; i++) push(W'(i));
    drain();
    check("stream_reads", 32'(rd_cycles.size()), 100);
    if (rd_cycles.size() == 100) check("stream_span", 32'(rd_cycles[99] - rd_cycles[0]), 99);

    rd_ready = 1'b0;
    push(16'h11);
    push(16'h22);
    @(posedge clk);
    #1;
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 16'h0077;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_valid = 1'b0;
    check("flush_occ", 32'(occ), 0);
    check("flush_valid", 32'(rd_valid), 0);
    check("flush_ready", 32'(wr_ready), 1);
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      flush    = ($urandom % 32) == 0;
      wr_valid = ($urandom % 4) != 0;
      wr_data  = W'($urandom);
      rd_ready = flush ? 1'b0 : (($urandom % 3) != 0);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    wr_valid = 1'b0;
    drain();

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    push(16'h5);
    push(16'h6);
    repeat (20) @(posedge clk);
    @(negedge clk);
`ifdef PIPELINE_SKID_STATS_EN
    check("stall_sat", 32'(stall_count), 15);
`endif
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(rd_valid), 0);
    check("async_rst_ready", 32'(wr_ready), 0);
    check("async_rst_occ", 32'(occ), 0);
`ifdef PIPELINE_SKID_STATS_EN
    check("async_rst_stall", 32'(stall_count), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
